rggen_wishbone_responder: RTL and testbench

// - Wishbone B4 pipelined slave that fronts an rggen register block's native bus (valid/access/address/strobe -> ready/status/data).
// - Lets a Wishbone master (host CPU or USB bridge) reach rggen-generated CSR blocks.
// - One transaction in flight. Requests and responses are registered.
// - An optional watchdog turns a hung register block into a Wishbone error.

---
 rtl/rggen_wishbone_responder_pkg.sv | 12 +
 rtl/rggen_rtl_macros.vh | 11 +
 rtl/rggen_wishbone_watchdog.sv | 26 ++
 rtl/rggen_wishbone_responder.sv | 142 ++++++++++++++
 tb/tb_rggen_wishbone_responder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/rggen_wishbone_responder_pkg.sv
// rggen_wishbone_responder_pkg: typed views of the shared rggen bus encodings
`include "rggen_rtl_macros.vh"
package rggen_wishbone_responder_pkg;
    localparam logic [1:0] ACCESS_READ        = `RGGEN_READ;
    localparam logic [1:0] ACCESS_WRITE       = `RGGEN_WRITE;
    localparam logic [1:0] STATUS_OKAY        = `RGGEN_OKAY;
    localparam logic [1:0] STATUS_SLAVE_ERROR = `RGGEN_SLAVE_ERROR;

    function automatic logic is_okay(input logic [1:0] status);
        return status == STATUS_OKAY;
    endfunction
endpackage

// File: rtl/rggen_rtl_macros.vh
// rggen_rtl_macros: access and status encodings shared by rggen bus adapters
`ifndef RGGEN_RTL_MACROS_VH
`define RGGEN_RTL_MACROS_VH
`define RGGEN_READ          2'b10
`define RGGEN_WRITE         2'b11
`define RGGEN_POSTED_WRITE  2'b01
`define RGGEN_OKAY          2'b00
`define RGGEN_EXOKAY        2'b01
`define RGGEN_SLAVE_ERROR   2'b10
`define RGGEN_DECODE_ERROR  2'b11
`endif

// File: rtl/rggen_wishbone_watchdog.sv
// rggen_wishbone_watchdog: down-counter that flags a register block that never answers
module rggen_wishbone_watchdog #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    assign o_expired = i_enable && (r_count == '0);

    // Loaded with the last allowed cycle, so expiry lands on the TIMEOUT_CYCLES-th enabled cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= CW'(TIMEOUT_CYCLES - 1);
        else if (i_enable && r_count != '0)
            r_count <= r_count - CW'(1);
    end
endmodule

// File: rtl/rggen_wishbone_responder.sv
// rggen_wishbone_responder: pipelined Wishbone B4 slave driving an rggen native register bus,
// one transaction in flight, with an optional watchdog that converts a hang into a bus error.
module rggen_wishbone_responder
    import rggen_wishbone_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic                     i_wb_we,
    input  logic [BUS_WIDTH-1:0]     i_wb_dat,
    input  logic [BUS_WIDTH/8-1:0]   i_wb_sel,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic                     o_wb_rty,
    output logic [BUS_WIDTH-1:0]     o_wb_dat,
    output logic                     o_bus_valid,
    output logic [1:0]               o_bus_access,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_accept;
    logic                     w_release;
    logic                     w_expired;
    logic                     w_okay;
    logic                     r_ack;
    logic                     r_err;
    logic [BUS_WIDTH-1:0]     r_wb_dat;
    logic                     r_bus_valid;
    logic [1:0]               r_bus_access;
    logic [ADDRESS_WIDTH-1:0] r_bus_address;
    logic [BUS_WIDTH-1:0]     r_bus_write_data;
    logic [BUS_WIDTH/8-1:0]   r_bus_strobe;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            rggen_wishbone_watchdog #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_watchdog (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_clear   (w_accept),
                .i_enable  ((r_state == BUSY || r_state == DRAIN) && !i_bus_ready),
                .o_expired (w_expired)
            );
        end else begin : g_no_watchdog
            assign w_expired = 1'b0;
        end
    endgenerate

    // w_release marks the cycle the outstanding rggen request ends, by ready or by watchdog
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = i_wb_cyc && i_wb_stb;
                w_next   = w_accept ? BUSY : IDLE;
            end
            BUSY: begin
                w_release = i_bus_ready || w_expired;
                w_next    = w_release ? RESP : (i_wb_cyc ? BUSY : DRAIN);
            end
            RESP: w_next = IDLE;
            default: begin
                w_release = i_bus_ready || w_expired;
                w_next    = w_release ? IDLE : DRAIN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    assign w_okay = i_bus_ready && is_okay(i_bus_status);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack            <= 1'b0;
            r_err            <= 1'b0;
            r_wb_dat         <= '0;
            r_bus_valid      <= 1'b0;
            r_bus_access     <= 2'b00;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_strobe     <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                r_bus_valid      <= 1'b1;
                r_bus_access     <= i_wb_we ? ACCESS_WRITE : ACCESS_READ;
                r_bus_address    <= i_wb_adr;
                r_bus_write_data <= i_wb_we ? i_wb_dat : '0;
                r_bus_strobe     <= i_wb_sel;
            end else if (w_release) begin
                r_bus_valid <= 1'b0;
            end
            // A drained transaction ends silently; only BUSY produces a response
            if (w_release && r_state == BUSY) begin
                r_ack    <= w_okay;
                r_err    <= !w_okay;
                r_wb_dat <= (w_okay && r_bus_access == ACCESS_READ) ? i_bus_read_data : '0;
            end
        end
    end

    assign o_wb_stall       = r_state != IDLE;
    assign o_wb_ack         = r_ack && i_wb_cyc;
    assign o_wb_err         = r_err && i_wb_cyc;
    assign o_wb_rty         = 1'b0;
    assign o_wb_dat         = r_wb_dat;
    assign o_bus_valid      = r_bus_valid;
    assign o_bus_access     = r_bus_access;
    assign o_bus_address    = r_bus_address;
    assign o_bus_write_data = r_bus_write_data;
    assign o_bus_strobe     = r_bus_strobe;
endmodule

// File: tb/tb_rggen_wishbone_responder.sv
// tb_rggen_wishbone_responder: directed and random transactions against a transaction-level model
module tb_rggen_wishbone_responder;
    import rggen_wishbone_responder_pkg::*;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_stall;
    logic [AW-1:0] wb_adr = '0;
    logic          wb_we = 1'b0;
    logic [BW-1:0] wb_dat_i = '0;
    logic [3:0]    wb_sel = '0;
    logic          wb_ack;
    logic          wb_err;
    logic          wb_rty;
    logic [BW-1:0] wb_dat_o;
    logic          bus_valid;
    logic [1:0]    bus_access;
    logic [AW-1:0] bus_address;
    logic [BW-1:0] bus_write_data;
    logic [3:0]    bus_strobe;
    logic          bus_ready = 1'b0;
    logic [1:0]    bus_status = 2'b00;
    logic [BW-1:0] bus_read_data = '0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    rggen_wishbone_responder #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wb_cyc         (wb_cyc),
        .i_wb_stb         (wb_stb),
        .o_wb_stall       (wb_stall),
        .i_wb_adr         (wb_adr),
        .i_wb_we          (wb_we),
        .i_wb_dat         (wb_dat_i),
        .i_wb_sel         (wb_sel),
        .o_wb_ack         (wb_ack),
        .o_wb_err         (wb_err),
        .o_wb_rty         (wb_rty),
        .o_wb_dat         (wb_dat_o),
        .o_bus_valid      (bus_valid),
        .o_bus_access     (bus_access),
        .o_bus_address    (bus_address),
        .o_bus_write_data (bus_write_data),
        .o_bus_strobe     (bus_strobe),
        .i_bus_ready      (bus_ready),
        .i_bus_status     (bus_status),
        .i_bus_read_data  (bus_read_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"}, 64'(wb_stall), 64'd0);
        check({tag, ".ack"}, 64'(wb_ack), 64'd0);
        check({tag, ".err"}, 64'(wb_err), 64'd0);
        check({tag, ".rty"}, 64'(wb_rty), 64'd0);
        check({tag, ".wb_dat"}, 64'(wb_dat_o), 64'd0);
        check({tag, ".valid"}, 64'(bus_valid), 64'd0);
        check({tag, ".access"}, 64'(bus_access), 64'd0);
        check({tag, ".address"}, 64'(bus_address), 64'd0);
        check({tag, ".wdata"}, 64'(bus_write_data), 64'd0);
        check({tag, ".strobe"}, 64'(bus_strobe), 64'd0);
    endtask

    // lat = idle rggen cycles before ready; lat < 0 means ready never comes.
    // abort drops cyc on the first cycle after acceptance.
    task automatic do_txn(input string tag, input bit we, input logic [AW-1:0] adr,
                          input logic [BW-1:0] dat, input logic [3:0] sel, input int lat,
                          input logic [1:0] st, input logic [BW-1:0] rd, input bit abort);
        bit            timed_out = (lat < 0) || (lat >= TO);
        int            valid_len = timed_out ? TO : lat + 1;
        bit            resp      = !(abort && (timed_out || lat > 0));
        bit            ok        = !timed_out && (st == STATUS_OKAY);
        logic [BW-1:0] exp_dat   = (ok && !we) ? rd : '0;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
        bus_ready = 1'b0;
        @(negedge clk);
        check({tag, ".accept_stall"}, 64'(wb_stall), 64'd0);
        for (int k = 0; k < valid_len; k++) begin
            @(posedge clk); #1;
            wb_cyc = !abort; wb_stb = 1'($urandom); wb_we = 1'($urandom);
            wb_adr = AW'($urandom); wb_dat_i = $urandom; wb_sel = 4'($urandom);
            bus_ready = !timed_out && (k == lat);
            bus_status = bus_ready ? st : 2'($urandom);
            bus_read_data = bus_ready ? rd : $urandom;
            @(negedge clk);
            check({tag, ".valid"}, 64'(bus_valid), 64'd1);
            check({tag, ".access"}, 64'(bus_access), 64'(we ? ACCESS_WRITE : ACCESS_READ));
            check({tag, ".address"}, 64'(bus_address), 64'(adr));
            check({tag, ".wdata"}, 64'(bus_write_data), we ? 64'(dat) : 64'd0);
            check({tag, ".strobe"}, 64'(bus_strobe), 64'(sel));
            check({tag, ".busy_stall"}, 64'(wb_stall), 64'd1);
            check({tag, ".busy_resp"}, {62'd0, wb_ack, wb_err}, 64'd0);
        end
        @(posedge clk); #1;
        wb_stb = 1'b0; bus_ready = 1'b0; bus_read_data = $urandom;
        @(negedge clk);
        check({tag, ".valid_drop"}, 64'(bus_valid), 64'd0);
        check({tag, ".post_stall"}, 64'(wb_stall), 64'(resp));
        check({tag, ".ack"}, 64'(wb_ack), 64'(resp && !abort && ok));
        check({tag, ".err"}, 64'(wb_err), 64'(resp && !abort && !ok));
        if (resp) begin
            check({tag, ".rdata"}, 64'(wb_dat_o), 64'(exp_dat));
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, ".idle_stall"}, 64'(wb_stall), 64'd0);
            check({tag, ".idle_resp"}, {62'd0, wb_ack, wb_err}, 64'd0);
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_txn("write", 1'b1, 8'h10, 32'hA5A5_0001, 4'hF, 2, STATUS_OKAY, 32'h0, 1'b0);
        do_txn("read", 1'b0, 8'h14, 32'h0, 4'hF, 1, STATUS_OKAY, 32'hDEAD_BEEF, 1'b0);
        do_txn("slverr", 1'b0, 8'h18, 32'h0, 4'h3, 0, STATUS_SLAVE_ERROR, 32'h1234_5678, 1'b0);
        do_txn("abort", 1'b1, 8'h20, 32'h0BAD_F00D, 4'h5, 5, STATUS_OKAY, 32'h0, 1'b1);
        do_txn("after_abort", 1'b0, 8'h24, 32'h0, 4'hF, 0, STATUS_OKAY, 32'hCAFE_0042, 1'b0);
        do_txn("abort_ready", 1'b0, 8'h28, 32'h0, 4'hF, 0, STATUS_OKAY, 32'h7777_0000, 1'b1);
        do_txn("timeout", 1'b0, 8'h2C, 32'h0, 4'hF, -1, STATUS_OKAY, 32'h0, 1'b0);
        do_txn("drain_timeout", 1'b1, 8'h30, 32'h1, 4'h1, -1, STATUS_OKAY, 32'h0, 1'b1);
        do_txn("last_cycle_ready", 1'b0, 8'h34, 32'h0, 4'hF, TO - 1, STATUS_OKAY, 32'h5A5A_A5A5, 1'b0);

        for (int i = 0; i < 40; i++)
            do_txn("random", 1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 9)), 2'($urandom), $urandom, $urandom_range(0, 4) == 0);

        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h40; wb_dat_i = 32'hFFFF_FFFF; wb_sel = 4'hF;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        @(negedge clk);
        check("rst_pre.valid", 64'(bus_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_all_zero("rst_busy");
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc = 1'b0;
        @(negedge clk);
        check("rst_release.stall", 64'(wb_stall), 64'd0);
        check("rst_release.valid", 64'(bus_valid), 64'd0);
        do_txn("post_reset", 1'b0, 8'h44, 32'h0, 4'hF, 3, STATUS_OKAY, 32'h0101_0202, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
